// File: rtl/mem_unit.sv
// mem_unit: multi-cycle memory unit for the multi-cycle CPU datapath.
//
// Picks the byte address from PC or ALUOut, holds the request for
// WAIT_CYCLES access cycles, then reads or writes an internal 32-bit word
// array on the last access edge and pulses ready for one cycle. Completed
// reads load dataout and MDR, and IR when IRWrite was set at accept.
//
// Optional feature macro: MEM_SUBWORD_EN
//   defined   : byte/half/word accesses with lane select, zero/sign
//               extension on reads and a misalignment check (err).
//   undefined : every access is a full word, size/sign_ext and A[1:0]
//               are ignored, err is always 0.
//
// Parameters:
//   ADDR_W      word-index width, array depth 2**ADDR_W words
//   WAIT_CYCLES access cycles per request (>= 1)
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req           access request, sampled only in IDLE
//   MemWrite      1 = write, 0 = read
//   IorD          address select: 0 = PC, 1 = ALUOut
//   IRWrite       load IR on read completion
//   size          00 byte, 01 half, 1x word
//   sign_ext      sign-extend sub-word reads
//   PC, ALUOut    byte addresses
//   wdata         store data
//   ready         one-cycle completion pulse
//   busy          high whenever the FSM is not IDLE
//   err           misaligned access dropped (only with ready)
//   dataout       last read result
//   MDR, IR       memory data register, instruction register
module mem_unit #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        MemWrite,
  input  logic        IorD,
  input  logic        IRWrite,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] PC,
  input  logic [31:0] ALUOut,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        busy,
  output logic        err,
  output logic [31:0] dataout,
  output logic [31:0] MDR,
  output logic [31:0] IR
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [31:0]         mem [2**ADDR_W];

  logic [31:0]         addr;
  logic [ADDR_W+1:0]   addr_q;
  logic                we_q, irw_q, err_q;
  logic [31:0]         wdata_q;
  logic [ADDR_W-1:0]   idx;
  logic [1:0]          lane;
  logic                commit;
  logic                misalign;
  logic [3:0]          be;
  logic [31:0]         wlane;
  logic [31:0]         rword;
  logic [31:0]         rfmt;
  logic                unused_bits;

  assign addr   = IorD ? ALUOut : PC;
  assign idx    = addr_q[ADDR_W+1:2];
  assign lane   = addr_q[1:0];
  assign commit = (state == ACCESS) && (cnt == '0);
  assign rword  = mem[idx];

  assign ready = (state == DONE);
  assign busy  = (state != IDLE);

`ifdef MEM_SUBWORD_EN
  logic [1:0] size_q;
  logic       sext_q;
  logic [7:0] rbyte;
  logic [15:0] rhalf;

  assign err         = (state == DONE) && err_q;
  assign unused_bits = ^addr[31:ADDR_W+2];

  always_ff @(posedge clk) begin
    if (rst) begin
      size_q <= 2'b00;
      sext_q <= 1'b0;
    end else if (state == IDLE && req) begin
      size_q <= size;
      sext_q <= sign_ext;
    end
  end

  // NOTE: every signal written here is given a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    misalign = 1'b0;
    be       = 4'b1111;
    wlane    = wdata_q;
    rbyte    = rword[{lane, 3'b000} +: 8];
    rhalf    = lane[1] ? rword[31:16] : rword[15:0];
    rfmt     = rword;
    case (size_q)
      2'b00: begin
        be    = 4'b0001 << lane;
        wlane = {4{wdata_q[7:0]}};
        rfmt  = {{24{sext_q & rbyte[7]}}, rbyte};
      end
      2'b01: begin
        misalign = lane[0];
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wlane    = {2{wdata_q[15:0]}};
        rfmt     = {{16{sext_q & rhalf[15]}}, rhalf};
      end
      default: misalign = (lane != 2'b00);
    endcase
  end
`else
  assign err         = 1'b0;
  assign misalign    = 1'b0;
  assign be          = 4'b1111;
  assign wlane       = wdata_q;
  assign rfmt        = rword;
  assign unused_bits = ^{addr[31:ADDR_W+2], lane, size, sign_ext, err_q};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      irw_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      dataout <= '0;
      MDR     <= '0;
      IR      <= '0;
    end else if (state == IDLE && req) begin
      cnt     <= CNT_W'(WAIT_CYCLES - 1);
      addr_q  <= addr[ADDR_W+1:0];
      we_q    <= MemWrite;
      irw_q   <= IRWrite;
      err_q   <= 1'b0;
      wdata_q <= wdata;
    end else if (state == ACCESS) begin
      if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end else begin
        err_q <= misalign;
        if (!we_q && !misalign) begin
          dataout <= rfmt;
          MDR     <= rfmt;
          if (irw_q) IR <= rfmt;
        end
      end
    end
  end

  // NOTE: the array has no reset; gating the write with !rst keeps a
  // request aborted on its commit edge from reaching the storage.
  always_ff @(posedge clk) begin
    if (!rst && commit && we_q && !misalign) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_unit.sv
// Directed self-checking bench for mem_unit (default WAIT_CYCLES=1 plus a
// WAIT_CYCLES=3 instance sharing the same inputs for latency checks).
module tb_mem_unit;

  logic        clk = 1'b0;
  logic        rst, req, MemWrite, IorD, IRWrite, sign_ext;
  logic [1:0]  size;
  logic [31:0] PC, ALUOut, wdata;
  logic        ready, busy, err;
  logic [31:0] dataout, MDR, IR;
  logic        ready3, busy3, err3;
  logic [31:0] dataout3, MDR3, IR3;

  int n_cmp  = 0;
  int n_fail = 0;
  int lat;
  logic e;

  always #5 clk = ~clk;

  mem_unit #(.ADDR_W(9), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .req(req), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .size(size), .sign_ext(sign_ext), .PC(PC),
    .ALUOut(ALUOut), .wdata(wdata), .ready(ready), .busy(busy), .err(err),
    .dataout(dataout), .MDR(MDR), .IR(IR)
  );

  mem_unit #(.ADDR_W(9), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .req(req), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .size(size), .sign_ext(sign_ext), .PC(PC),
    .ALUOut(ALUOut), .wdata(wdata), .ready(ready3), .busy(busy3), .err(err3),
    .dataout(dataout3), .MDR(MDR3), .IR(IR3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. Returns the cycle (counted from
  // the accept edge) in which ready was seen and err in that cycle, then
  // steps one more cycle so the DUT is idle again.
  task automatic access(input logic we, input logic iord, input logic irw,
                        input logic [1:0] sz, input logic sx,
                        input logic [31:0] pc, input logic [31:0] alu,
                        input logic [31:0] wd,
                        output int l, output logic er);
    MemWrite = we; IorD = iord; IRWrite = irw; size = sz; sign_ext = sx;
    PC = pc; ALUOut = alu; wdata = wd; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    l  = 0;
    er = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (ready) begin
        l  = i;
        er = err;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    int lat1, lat3;
    rst = 1'b1; req = 1'b0; MemWrite = 1'b0; IorD = 1'b0; IRWrite = 1'b0;
    size = 2'b10; sign_ext = 1'b0; PC = '0; ALUOut = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_ready",   32'(ready), 32'd0);
    check("rst_busy",    32'(busy),  32'd0);
    check("rst_err",     32'(err),   32'd0);
    check("rst_ir",      IR,         32'd0);
    check("rst_mdr",     MDR,        32'd0);
    check("rst_dataout", dataout,    32'd0);

    // Preload word 1 via a PC-addressed write; measure both latencies
    MemWrite = 1'b1; IorD = 1'b0; IRWrite = 1'b0; size = 2'b10;
    PC = 32'h4; ALUOut = 32'h100; wdata = 32'h8C220008; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    lat1 = 0; lat3 = 0;
    for (int i = 1; i <= 20; i++) begin
      if (ready  && lat1 == 0) lat1 = i;
      if (ready3 && lat3 == 0) lat3 = i;
      if (lat1 != 0 && lat3 != 0) break;
      @(negedge clk);
    end
    check("lat_wait1", 32'(lat1), 32'd2);
    check("lat_wait3", 32'(lat3), 32'd4);
    repeat (2) @(negedge clk);
    check("wr_keeps_mdr", MDR, 32'd0);
    check("wr_keeps_ir",  IR,  32'd0);

    // Instruction fetch
    access(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'h200, 32'h0, lat, e);
    check("fetch_lat", 32'(lat), 32'd2);
    check("fetch_ir",  IR,      32'h8C220008);
    check("fetch_mdr", MDR,     32'h8C220008);
    check("fetch_err", 32'(e),  32'd0);

    // Store then load through ALUOut
    access(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'h10, 32'hDEADBEEF, lat, e);
    check("st_ir_kept",  IR,  32'h8C220008);
    check("st_mdr_kept", MDR, 32'h8C220008);
    access(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h10, 32'h0, lat, e);
    check("ld_dataout", dataout, 32'hDEADBEEF);
    check("ld_mdr",     MDR,     32'hDEADBEEF);
    check("ld_ir_kept", IR,      32'h8C220008);

    // Sub-word accesses around word 0x20
    access(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h20, 32'h11223344, lat, e);
    access(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h21, 32'h555555AA, lat, e);
    access(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h20, 32'h0, lat, e);
`ifdef MEM_SUBWORD_EN
    check("sb_word", dataout, 32'h1122AA44);
    access(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0, 32'h21, 32'h0, lat, e);
    check("lb_signed", dataout, 32'hFFFFFFAA);
    access(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0, 32'h22, 32'h0, lat, e);
    check("lhu", dataout, 32'h00001122);
    access(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h22, 32'h0, lat, e);
    check("lw_mis_err", 32'(e), 32'd1);
    check("lw_mis_lat", 32'(lat), 32'd2);
    check("lw_mis_mdr", MDR, 32'h00001122);
    access(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0, 32'h21, 32'h0, lat, e);
    check("lh_odd_err", 32'(e), 32'd1);
`else
    check("sb_word_full", dataout, 32'h555555AA);
    access(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0, 32'h21, 32'h0, lat, e);
    check("lb_as_word", dataout, 32'h555555AA);
    access(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h22, 32'h0, lat, e);
    check("lw_unal_err", 32'(e), 32'd0);
    check("lw_unal_mdr", MDR, 32'h555555AA);
`endif

    // Address wrap: 0x804 aliases word 1
    access(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h804, 32'h0BADF00D, lat, e);
    access(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h0, lat, e);
    check("wrap_alias", dataout, 32'h0BADF00D);

    // Write aborted by reset on its commit edge
    access(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h30, 32'h12345678, lat, e);
    MemWrite = 1'b1; IorD = 1'b1; size = 2'b10; ALUOut = 32'h30;
    wdata = 32'hFFFFFFFF; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",  32'(busy), 32'd0);
    check("abort_mdr",   MDR,       32'd0);
    @(negedge clk);
    access(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h30, 32'h0, lat, e);
    check("abort_kept", dataout, 32'h12345678);

    // req held through DONE: next accept only in the following IDLE cycle
    repeat (4) @(negedge clk);
    MemWrite = 1'b0; IorD = 1'b1; IRWrite = 1'b0; size = 2'b10;
    ALUOut = 32'h10; req = 1'b1;
    @(negedge clk);
    check("hold_access", 32'(busy),  32'd1);
    @(negedge clk);
    check("hold_done",   32'(ready), 32'd1);
    @(negedge clk);
    check("hold_idle",   32'(busy),  32'd0);
    @(negedge clk);
    req = 1'b0;
    check("hold_reacc",  32'(busy),  32'd1);
    @(negedge clk);
    check("hold_ready2", 32'(ready), 32'd1);
    check("hold_data",   dataout,    32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
